// File: rtl/prvp_pulp_clock_divider.sv
// Integer clock divider: clk_o is a flop output, and ratio/enable/polarity changes apply only at period boundaries.
// Ratio handshake: div_ready_o drops for one pending request until the next boundary. PRVP_CLKDIV_INVERT_EN enables the invert_i polarity flop.
module prvp_pulp_clock_divider #(
  parameter int          DIV_WIDTH   = 8,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clk_en_i,
  input  logic                 invert_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic                 div_valid_i,
  output logic                 div_ready_o,
  output logic [DIV_WIDTH-1:0] cur_div_o,
  output logic                 clk_o
);

  localparam logic [DIV_WIDTH-1:0] DEF_DIV = DIV_WIDTH'(DEFAULT_DIV);
  localparam logic [DIV_WIDTH-1:0] MIN_DIV = DIV_WIDTH'(2);
  localparam logic [DIV_WIDTH-1:0] ONE     = DIV_WIDTH'(1);

  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_e;

  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] pend_q, pend_d;
  logic [DIV_WIDTH-1:0] half_d;
  logic                 en_q, en_d;
  logic                 clk_q, clk_d;
  logic                 boundary;
  logic                 xfer;

  assign boundary = (cnt_q == div_q - ONE) || !en_q;
  assign xfer     = div_valid_i && div_ready_o;

  // FSM: state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // FSM: next state; a request accepted on a boundary waits for the next one
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (xfer)     state_d = PEND;
      PEND:    if (boundary) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    div_ready_o = 1'b0;
    if (state_q == IDLE) div_ready_o = 1'b1;
  end

`ifdef PRVP_CLKDIV_INVERT_EN
  logic inv_q, inv_d;

  assign inv_d = boundary ? invert_i : inv_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) inv_q <= 1'b0;
    else         inv_q <= inv_d;
  end
`else
  logic inv_q, inv_d;
  logic unused_invert;

  assign inv_q         = 1'b0;
  assign inv_d         = inv_q;
  assign unused_invert = invert_i;
`endif

  always_comb begin
    cnt_d  = boundary ? '0 : cnt_q + ONE;
    en_d   = boundary ? clk_en_i : en_q;
    div_d  = (boundary && state_q == PEND) ? pend_q : div_q;
    pend_d = pend_q;
    if (xfer) pend_d = (div_i < MIN_DIV) ? MIN_DIV : div_i;
    half_d = div_d >> 1;
    // Output is computed from next-state values so the flop tracks the new count.
    clk_d  = en_d ? ((cnt_d < half_d) ^ inv_d) : inv_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      div_q  <= DEF_DIV;
      pend_q <= DEF_DIV;
      en_q   <= 1'b0;
      clk_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      pend_q <= pend_d;
      en_q   <= en_d;
      clk_q  <= clk_d;
    end
  end

  assign cur_div_o = div_q;
  assign clk_o     = clk_q;

endmodule

// File: tb/tb_prvp_pulp_clock_divider.sv
// Directed bench for prvp_pulp_clock_divider; expected waveforms are hand-derived bit patterns.
module tb_prvp_pulp_clock_divider;

  logic       clk;
  logic       rst_n;
  logic       clk_en;
  logic       invert;
  logic [7:0] div;
  logic       div_valid;
  logic       div_ready;
  logic [7:0] cur_div;
  logic       clk_div;

  int n_chk  = 0;
  int n_fail = 0;

  prvp_pulp_clock_divider #(.DIV_WIDTH(8), .DEFAULT_DIV(2)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clk_en_i    (clk_en),
    .invert_i    (invert),
    .div_i       (div),
    .div_valid_i (div_valid),
    .div_ready_o (div_ready),
    .cur_div_o   (cur_div),
    .clk_o       (clk_div)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n cycles, checking clk_o against bits (MSB = first cycle).
  task automatic wave(input string tag, input int n, input logic [31:0] bits);
    for (int i = 0; i < n; i++) begin
      tick();
      chk(tag, {31'b0, clk_div}, {31'b0, bits[n-1-i]});
    end
  endtask

  initial begin
    rst_n = 1'b1; clk_en = 1'b0; invert = 1'b0; div = 8'd0; div_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_clk", {31'b0, clk_div}, 32'd0);
    chk("reset_rdy", {31'b0, div_ready}, 32'd1);
    chk("reset_div", {24'b0, cur_div}, 32'd2);
    tick(); tick();
    chk("reset_hold_clk", {31'b0, clk_div}, 32'd0);

    // Release with enable: R=2 toggles every cycle
    clk_en = 1'b1; rst_n = 1'b1;
    wave("r2_toggle", 5, 32'b10101);
    chk("r2_div", {24'b0, cur_div}, 32'd2);

    // Ratio 5 requested mid-period
    div_valid = 1'b1; div = 8'd5;
    tick();
    chk("r5_rdy_pend", {31'b0, div_ready}, 32'd0);
    chk("r5_div_old", {24'b0, cur_div}, 32'd2);
    chk("r5_clk_pend", {31'b0, clk_div}, 32'd0);
    div_valid = 1'b0;
    tick();
    chk("r5_div_new", {24'b0, cur_div}, 32'd5);
    chk("r5_rdy_back", {31'b0, div_ready}, 32'd1);
    chk("r5_clk_first", {31'b0, clk_div}, 32'd1);
    wave("r5_period", 5, 32'b10001);

    // Ratio 0 clamps to 2
    div_valid = 1'b1; div = 8'd0;
    tick();
    chk("clamp_rdy", {31'b0, div_ready}, 32'd0);
    chk("clamp_clk", {31'b0, clk_div}, 32'd1);
    chk("clamp_div_old", {24'b0, cur_div}, 32'd5);
    div_valid = 1'b0;
    wave("clamp_tail", 4, 32'b0001);
    chk("clamp_div", {24'b0, cur_div}, 32'd2);
    chk("clamp_rdy_back", {31'b0, div_ready}, 32'd1);

    // Move to R=4, then drop enable during the high phase
    div_valid = 1'b1; div = 8'd4;
    tick();
    chk("r4_clk_pend", {31'b0, clk_div}, 32'd0);
    div_valid = 1'b0;
    tick();
    chk("r4_div", {24'b0, cur_div}, 32'd4);
    chk("r4_clk_first", {31'b0, clk_div}, 32'd1);
    clk_en = 1'b0;
    wave("en_drop_drain", 6, 32'b100000);
    clk_en = 1'b1;
    wave("en_restart", 5, 32'b11001);

    // R=4 -> 3, then a 3 -> 6 request coincident with a boundary
    div_valid = 1'b1; div = 8'd3;
    tick();
    chk("r3_clk_pend", {31'b0, clk_div}, 32'd1);
    div_valid = 1'b0;
    wave("r3_load", 3, 32'b001);
    chk("r3_div", {24'b0, cur_div}, 32'd3);
    wave("r3_period", 2, 32'b00);
    div_valid = 1'b1; div = 8'd6;
    tick();
    chk("r6_coinc_clk", {31'b0, clk_div}, 32'd1);
    chk("r6_coinc_rdy", {31'b0, div_ready}, 32'd0);
    chk("r6_coinc_div", {24'b0, cur_div}, 32'd3);
    div_valid = 1'b0;
    wave("r6_extra_r3", 3, 32'b001);
    chk("r6_div", {24'b0, cur_div}, 32'd6);
    wave("r6_period", 6, 32'b110001);

    // Reset mid-period with a pending ratio
    div_valid = 1'b1; div = 8'd9;
    tick();
    chk("rst_pend_rdy", {31'b0, div_ready}, 32'd0);
    chk("rst_pend_clk", {31'b0, clk_div}, 32'd1);
    div_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_mid_clk", {31'b0, clk_div}, 32'd0);
    chk("rst_mid_rdy", {31'b0, div_ready}, 32'd1);
    chk("rst_mid_div", {24'b0, cur_div}, 32'd2);
    tick();
    rst_n = 1'b1;
    wave("post_rst", 3, 32'b101);
    chk("post_rst_div", {24'b0, cur_div}, 32'd2);

    // Polarity request applied at the R=4 switch
    div_valid = 1'b1; div = 8'd4; invert = 1'b1;
    tick();
    chk("inv_clk_pend", {31'b0, clk_div}, 32'd0);
    div_valid = 1'b0;
`ifdef PRVP_CLKDIV_INVERT_EN
    wave("inv_period", 5, 32'b00110);
    clk_en = 1'b0;
    wave("inv_hold", 5, 32'b01111);
`else
    wave("inv_ignored", 5, 32'b11001);
    clk_en = 1'b0;
    wave("inv_ignored_hold", 5, 32'b10000);
`endif
    #3 rst_n = 1'b0;
    #1;
    chk("final_rst_clk", {31'b0, clk_div}, 32'd0);
    chk("final_rst_rdy", {31'b0, div_ready}, 32'd1);
    tick();
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
